python_bitslip_aligner: RTL and testbench

- Word-alignment controller for the PYTHON LVDS 10-bit deserializer.
- Monitors the deserialized sync lane, issues single-cycle bitslip pulses until the sensor training word lands on the 10-bit boundary, then reports lock.
- Sits in the deserializer's divided-clock domain, between deserializer outputs and frame decoder; started by software after sensor training mode is enabled.

---
 rtl/python_bitslip_aligner.sv | 114 +++++++++++
 tb/tb_python_bitslip_aligner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/python_bitslip_aligner.sv
// python_bitslip_aligner: pulses bitslip until the sync lane shows TRAINING_WORD, then reports lock.
// Optional per-lane data check is enabled by defining PYTHON_BITSLIP_ALIGNER_DATA_CHECK_EN.
module python_bitslip_aligner #(
  parameter int         CHANNELS      = 4,
  parameter logic [9:0] TRAINING_WORD = 10'h3a6,
  parameter int         SLIP_WAIT     = 4,
  parameter int         MATCH_COUNT   = 16,
  parameter int         MAX_SLIPS     = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [9:0]               in_sync,
  input  logic [CHANNELS*10-1:0]   in_data,
  output logic                     bitslip,
  output logic                     busy,
  output logic                     locked,
  output logic                     failed,
`ifdef PYTHON_BITSLIP_ALIGNER_DATA_CHECK_EN
  output logic [CHANNELS-1:0]      lane_error,
`endif
  output logic [3:0]               slip_count
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_SLIP   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;
  localparam logic [3:0] SW = SLIP_WAIT[3:0];
  localparam logic [7:0] MC = MATCH_COUNT[7:0];
  localparam logic [3:0] MS = MAX_SLIPS[3:0];

  logic [2:0] state_q, state_d;
  logic [3:0] wait_q, wait_d, slip_q, slip_d;
  logic [7:0] match_q, match_d;
  logic       hit;

`ifdef PYTHON_BITSLIP_ALIGNER_DATA_CHECK_EN
  logic [CHANNELS-1:0] lane_bad, lane_err_q;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign lane_bad[i] = in_data[i*10 +: 10] != TRAINING_WORD;
  end
  assign hit = (in_sync == TRAINING_WORD) && ~|lane_bad;
  assign lane_error = lane_err_q;
  always_ff @(posedge clk) begin
    if (!reset_n || start)
      lane_err_q <= '0;
    else if (state_q == S_CHECK && (state_d == S_LOCKED || state_d == S_FAIL))
      lane_err_q <= lane_bad;
  end
`else
  logic unused_data;
  assign unused_data = ^in_data;
  assign hit = in_sync == TRAINING_WORD;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    slip_d  = slip_q;
    match_d = match_q;
    if (start) begin
      state_d = S_WAIT;
      wait_d  = SW;
      slip_d  = '0;
      match_d = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          state_d = (wait_q == '0) ? S_CHECK : S_WAIT;
          wait_d  = (wait_q == '0) ? wait_q : wait_q - 4'd1;
          match_d = (wait_q == '0) ? '0 : match_q;
        end
        S_CHECK: begin
          match_d = hit ? match_q + 8'd1 : match_q;
          state_d = hit ? ((match_q + 8'd1 == MC) ? S_LOCKED : S_CHECK)
                        : ((slip_q == MS) ? S_FAIL : S_SLIP);
        end
        S_SLIP: begin
          state_d = S_WAIT;
          wait_d  = SW;
          slip_d  = slip_q + {3'd0, slip_q != 4'hf};
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      slip_q  <= '0;
      match_q <= '0;
      bitslip <= 1'b0;
      busy    <= 1'b0;
      locked  <= 1'b0;
      failed  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      slip_q  <= slip_d;
      match_q <= match_d;
      bitslip <= state_d == S_SLIP;
      busy    <= state_d == S_WAIT || state_d == S_CHECK || state_d == S_SLIP;
      locked  <= state_d == S_LOCKED;
      failed  <= state_d == S_FAIL;
    end
  end

  assign slip_count = slip_q;
endmodule

// File: tb/tb_python_bitslip_aligner.sv
// tb_python_bitslip_aligner: directed bench with a rotating-deserializer model on the sync lane.
module tb_python_bitslip_aligner;
  localparam logic [9:0] TW = 10'h3a6;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [9:0]  in_sync;
  logic [39:0] in_data;
  logic        bitslip, busy, locked, failed;
  logic [3:0]  slip_count;
`ifdef PYTHON_BITSLIP_ALIGNER_DATA_CHECK_EN
  logic [3:0]  lane_error;
`endif

  int checks = 0, failures = 0;
  int mode, r0, rot, n;
  logic corrupt, clr;
  int pulses, width, max_w, gap, min_gap;
  logic seen;

  always #5 clk = ~clk;

  python_bitslip_aligner dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_sync(in_sync), .in_data(in_data),
    .bitslip(bitslip), .busy(busy), .locked(locked), .failed(failed),
`ifdef PYTHON_BITSLIP_ALIGNER_DATA_CHECK_EN
    .lane_error(lane_error),
`endif
    .slip_count(slip_count)
  );

  function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
    logic [19:0] d;
    d = {w, w} << k;
    return d[19:10];
  endfunction

  // Each observed bitslip pulse walks the model one position back toward alignment.
  always_comb begin
    rot = ((r0 - pulses) % 10 + 10) % 10;
    in_sync = (mode == 1) ? 10'h000 : (rotl(TW, rot) ^ (corrupt ? 10'h001 : 10'h000));
    for (int i = 0; i < 4; i++)
      in_data[i*10 +: 10] = (mode == 2) ? ((i == 2) ? 10'h155 : TW) : in_sync;
  end

  always @(posedge clk) begin
    if (clr) begin
      pulses <= 0; width <= 0; max_w <= 0; gap <= 0; min_gap <= 1000; seen <= 1'b0;
    end else if (bitslip) begin
      width <= width + 1;
      if (width + 1 > max_w) max_w <= width + 1;
      if (width == 0) begin
        pulses <= pulses + 1;
        if (seen && gap < min_gap) min_gap <= gap;
        seen <= 1'b1;
      end
      gap <= 0;
    end else begin
      width <= 0;
      gap <= gap + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!(locked || failed) && cyc < max) begin
      tick();
      cyc++;
    end
    if (!(locked || failed)) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_slips(input int cnt);
    int k = 0;
    while (slip_count != cnt[3:0] && k < 300) begin tick(); k++; end
    if (slip_count != cnt[3:0]) chk("slip_timeout", slip_count, cnt);
  endtask

  task automatic wait_pulse();
    int k = 0;
    while (!bitslip && k < 300) begin tick(); k++; end
    if (!bitslip) chk("pulse_timeout", 0, 1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 0; r0 = 0; corrupt = 1'b0; clr = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    chk("rst_bitslip", bitslip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_failed", failed, 0);
    chk("rst_slips", slip_count, 0);
    reset_n = 1'b1;
    tick();

    // Misaligned by three positions
    r0 = 3; clear_mon(); kick();
    chk("t1_busy", busy, 1);
    wait_done(1000, n);
    chk("t1_locked", locked, 1);
    chk("t1_pulses", pulses, 3);
    chk("t1_width", max_w, 1);
    chk("t1_gap_ge5", int'(min_gap >= 5), 1);
    chk("t1_slips", slip_count, 3);
    chk("t1_busy_end", busy, 0);
    chk("t1_failed", failed, 0);

    // Already aligned: lock latency
    r0 = 0; clear_mon(); kick();
    wait_done(200, n);
    chk("t2_latency", int'(n >= 21 && n <= 23), 1);
    chk("t2_locked", locked, 1);
    chk("t2_pulses", pulses, 0);
    chk("t2_slips", slip_count, 0);

    // Dead sync lane exhausts the slip budget
    mode = 1; clear_mon(); kick();
    wait_done(2000, n);
    chk("t3_failed", failed, 1);
    chk("t3_busy", busy, 0);
    chk("t3_locked", locked, 0);
    chk("t3_slips", slip_count, 10);
    chk("t3_pulses", pulses, 10);

    // Corrupt word after 8 matches, then nine more slips bring alignment back
    mode = 0; r0 = 0; clear_mon(); kick();
    repeat (13) tick();
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    wait_done(2000, n);
    chk("t4_locked", locked, 1);
    chk("t4_slips", slip_count, 10);
    chk("t4_pulses", pulses, 10);

    // Restart during WAIT, restart on a SLIP cycle, reset on a SLIP cycle
    r0 = 5; clear_mon(); kick();
    wait_slips(2);
    tick();
    kick();
    chk("t5_restart_slips", slip_count, 0);
    chk("t5_restart_busy", busy, 1);
    wait_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_slipstart_slips", slip_count, 0);
    chk("t5_slipstart_bitslip", bitslip, 0);
    chk("t5_slipstart_busy", busy, 1);
    wait_pulse();
    reset_n = 1'b0;
    tick();
    chk("t5_rst_bitslip", bitslip, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_locked", locked, 0);
    chk("t5_rst_failed", failed, 0);
    chk("t5_rst_slips", slip_count, 0);
    reset_n = 1'b1;
    tick();

`ifdef PYTHON_BITSLIP_ALIGNER_DATA_CHECK_EN
    // Lane 2 stuck while sync is aligned
    mode = 2; r0 = 0; clear_mon(); kick();
    wait_done(2000, n);
    chk("t6_failed", failed, 1);
    chk("t6_slips", slip_count, 10);
    chk("t6_lane_error", lane_error, 4);
    chk("t6_pulses", pulses, 10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
